// File: rtl/fifo_pack_pkg.sv
// Shared types and constants for the FIFO word packer.
package fifo_pack_pkg;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_PACK    = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed-word stream handshake.
interface fifo_word_packer_if
  import fifo_pack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PACK  = DEF_PACK
);
  localparam int CW = clog2(PACK + 1);

  logic                    empty;
  logic [WIDTH-1:0]        dIn;
  logic                    rEn;
  logic [WIDTH*PACK-1:0]   oData;
  logic [CW-1:0]           oCount;
  logic                    oValid;
  logic                    oReady;

  modport master (
    input  empty, dIn, oReady,
    output rEn, oData, oCount, oValid
  );

  modport slave (
    output empty, dIn, oReady,
    input  rEn, oData, oCount, oValid
  );

endinterface

// File: rtl/fifo_pack_timer.sv
// Idle counter that flushes a partial word after TIMEOUT idle cycles.
module fifo_pack_timer
  import fifo_pack_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int TW = clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Fires on the edge that would bring the count to TIMEOUT.
  assign expired = inc & (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs PACK FIFO words into one wide stream word.
// Define PACK_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PACK    = DEF_PACK,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  fifo_word_packer_if.master  bus
);

  localparam int CW = clog2(PACK + 1);
  localparam int DW = WIDTH * PACK;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  count_q, count_d;
  logic [DW-1:0]  data_q, data_d;
  logic           pop;
  logic           tmo;

  assign pop = rst & (state_q == FILL) & ~bus.empty;

  assign bus.rEn    = pop;
  assign bus.oData  = data_q;
  assign bus.oCount = count_q;
  assign bus.oValid = (state_q == HOLD);

`ifdef PACK_TIMEOUT_EN
  logic t_clr;
  logic t_inc;

  assign t_inc = (state_q == FILL) & (cnt_q != '0) & bus.empty;
  assign t_clr = pop | (state_q != FILL);

  fifo_pack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (t_clr),
    .inc     (t_inc),
    .expired (tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    data_d  = data_q;
    unique case (1'b1)
      (state_q == FILL): begin
        if (pop) begin
          for (int i = 0; i < PACK; i++) begin
            if (cnt_q == CW'(i)) begin
              data_d[i*WIDTH +: WIDTH] = bus.dIn;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(PACK - 1)) begin
            state_d = HOLD;
            count_d = CW'(PACK);
          end
        end else if (tmo) begin
          state_d = HOLD;
          count_d = cnt_q;
        end
      end
      (state_q == HOLD): begin
        if (bus.oReady) begin
          state_d = FILL;
          cnt_d   = '0;
          count_d = '0;
          data_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer with a FIFO model.
module tb_fifo_word_packer;
  import fifo_pack_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int P     = DEF_PACK;
  localparam int T     = DEF_TIMEOUT;
  localparam int DW    = W * P;
  localparam int DEPTH = 8;
  localparam int NWRAP = 72;
  localparam int NRND  = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_word_packer_if #(.WIDTH(W), .PACK(P)) bus ();

  fifo_word_packer #(
    .WIDTH   (W),
    .PACK    (P),
    .TIMEOUT (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop = 0;

  logic [W-1:0]  fq[$];
  logic [W-1:0]  sent[$];
  logic [DW-1:0] got_d[$];
  int            got_c[$];

  typedef struct packed {
    logic [P-1:0][W-1:0] w;
    logic [DW-1:0]       exp;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    bus.empty = (fq.size() == 0);
    bus.dIn   = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    drive();
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    while (!bus.oValid && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input int k);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < P; i++) begin
      r = r | (DW'(sent[k*P + i]) << (W * i));
    end
    return r;
  endfunction

  // FIFO model: pop consumed word just after the edge, and log outputs.
  always @(posedge clk) begin
    bit pn;
    cyc++;
    pn = bus.rEn;
    if (pn) last_pop = cyc;
    if (rst && bus.oValid && bus.oReady) begin
      got_d.push_back(bus.oData);
      got_c.push_back(int'(bus.oCount));
    end
    if (pn) begin
      #1;
      void'(fq.pop_front());
      drive();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int idx;
    int guard;
    logic [W-1:0] w;

    tv[0] = '{w: {6'd4, 6'd3, 6'd2, 6'd1},     exp: 24'h103081};
    tv[1] = '{w: {6'd8, 6'd7, 6'd6, 6'd5},     exp: 24'h207185};
    tv[2] = '{w: {6'd12, 6'd11, 6'd10, 6'd9},  exp: 24'h30B289};
    tv[3] = '{w: {6'd63, 6'd62, 6'd61, 6'd60}, exp: 24'hFFEF7C};
    tv[4] = '{w: {6'd3, 6'd2, 6'd1, 6'd0},     exp: 24'h0C2040};
    tv[5] = '{w: {6'd0, 6'd63, 6'd0, 6'd63},   exp: 24'h03F03F};

    bus.oReady = 1'b1;
    drive();
    rst = 1'b0;

    // Reset held with a non-empty FIFO.
    @(negedge clk);
    push(6'd1);
    push(6'd2);
    push(6'd3);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ren", bus.rEn, 0);
      chk("rst_valid", bus.oValid, 0);
      chk("rst_data", bus.oData, 0);
      chk("rst_count", bus.oCount, 0);
    end
    fq.delete();
    drive();
    rst = 1'b1;
    @(negedge clk);

    // Table vectors with oReady held high.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < P; i++) push(tv[k].w[i]);
      wait_valid(20, n);
      chk($sformatf("vec%0d_valid", k), bus.oValid, 1);
      if (k == 0) chk("latency", n, P);
      chk($sformatf("vec%0d_data", k), bus.oData, tv[k].exp);
      chk($sformatf("vec%0d_count", k), bus.oCount, P);
      @(negedge clk);
      chk($sformatf("vec%0d_onecyc", k), bus.oValid, 0);
    end

    // Backpressure: output held, no pops, FIFO fills.
    bus.oReady = 1'b0;
    for (int i = 1; i <= 4; i++) push(W'(i));
    wait_valid(20, n);
    chk("bp_valid", bus.oValid, 1);
    for (int i = 5; i <= 12; i++) push(W'(i));
    repeat (10) begin
      @(negedge clk);
      chk("bp_data", bus.oData, 24'h103081);
      chk("bp_ren", bus.rEn, 0);
    end
    chk("bp_full", fq.size(), DEPTH);
    bus.oReady = 1'b1;
    @(negedge clk);
    wait_valid(20, n);
    chk("bp_next", bus.oData, 24'h207185);
    @(negedge clk);
    wait_valid(20, n);
    chk("bp_next2", bus.oData, 24'h30B289);
    @(negedge clk);

    // Random timing: wrap stream then random data, vs reference.
    sent.delete();
    got_d.delete();
    got_c.delete();
    idx = 0;
    guard = 0;
    while ((idx < NWRAP + NRND || got_d.size() < (NWRAP + NRND) / P)
           && guard < 5000) begin
      @(negedge clk);
      guard++;
      bus.oReady = ($urandom_range(0, 3) != 0);
      if (idx < NWRAP + NRND && fq.size() < DEPTH &&
          $urandom_range(0, 3) != 0) begin
        w = (idx < NWRAP) ? W'(idx % 64) : W'($urandom);
        push(w);
        sent.push_back(w);
        idx++;
      end
    end
    bus.oReady = 1'b1;
    chk("rnd_nout", got_d.size(), (NWRAP + NRND) / P);
    for (int k = 0; k < got_d.size() && k < (NWRAP + NRND) / P; k++) begin
      chk($sformatf("rnd%0d_data", k), got_d[k], ref_word(k));
      chk($sformatf("rnd%0d_count", k), got_c[k], P);
    end
    if (got_d.size() >= 18) begin
      chk("wrap_lanes63", got_d[15], 24'hFFEF7C);
      chk("wrap_lanes3", got_d[16], 24'h0C2040);
    end
    @(negedge clk);

    // Partial word: flushed by timeout or left waiting.
    push(6'd5);
    push(6'd6);
`ifdef PACK_TIMEOUT_EN
    wait_valid(40, n);
    chk("tmo_valid", bus.oValid, 1);
    chk("tmo_delay", cyc - last_pop, T);
    chk("tmo_count", bus.oCount, 2);
    chk("tmo_data", bus.oData, 24'h000185);
    @(negedge clk);
    chk("tmo_onecyc", bus.oValid, 0);
`else
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.oValid) n++;
    end
    chk("notmo_quiet", n, 0);
    chk("notmo_popped", fq.size(), 0);
    push(6'd7);
    push(6'd8);
    wait_valid(20, n);
    chk("notmo_data", bus.oData, 24'h207185);
    chk("notmo_count", bus.oCount, P);
    @(negedge clk);
`endif

    // Reset mid-fill discards popped lanes.
    push(6'd1);
    push(6'd2);
    @(negedge clk);
    @(negedge clk);
    chk("mid_popped", fq.size(), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_valid", bus.oValid, 0);
    chk("mid_data", bus.oData, 0);
    #3 rst = 1'b1;
    @(negedge clk);
    got_d.delete();
    got_c.delete();
    for (int i = 9; i <= 12; i++) push(W'(i));
    wait_valid(20, n);
    chk("mid_out_data", bus.oData, 24'h30B289);
    chk("mid_out_count", bus.oCount, P);
    @(negedge clk);
    @(negedge clk);
    chk("mid_nout", got_d.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
